sharpen_writeback_stage: RTL and testbench



---
 rtl/sharpen_pkg.sv | 15 +
 rtl/sharpen_wb_fifo.sv | 54 +++++
 rtl/sharpen_writeback_stage.sv | 141 ++++++++++++++
 tb/tb_sharpen_writeback_stage.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sharpen_pkg.sv
// Shared geometry, widths and write-back FSM state type for the 800x600 sharpening pipeline.
package sharpen_pkg;

  localparam int IMG_W     = 800;
  localparam int IMG_H     = 600;
  localparam int PIX_TOTAL = IMG_W * IMG_H;
  localparam int ADDR_W    = 19;
  localparam int PIX_W     = 8;
  localparam int RES_W     = 12;
  // Padded line stride, used by the fetch side for the one-pixel filter border.
  localparam int PAD_W     = IMG_W + 2;

  typedef enum logic [1:0] {IDLE, RUN, DONE} wb_state_t;

endpackage

// File: rtl/sharpen_wb_fifo.sv
// Small synchronous FIFO that absorbs compute-stage results while the output memory stalls.
module sharpen_wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 12
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    full    = (count == FULL_CNT);
    empty   = (count == '0);
    do_push = push && !full;
    do_pop  = pop && !empty;
    head    = mem[rd_ptr];
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sharpen_writeback_stage.sv
// Write-back stage: saturates results to pixels and writes them in raster order to frame memory.
// Optional macro SHARPEN_WB_CHECKSUM_EN adds a mod-2^16 checksum of written pixels.
module sharpen_writeback_stage
  import sharpen_pkg::*;
#(
  parameter int IMG_W      = sharpen_pkg::IMG_W,
  parameter int IMG_H      = sharpen_pkg::IMG_H,
  parameter int ADDR_W     = sharpen_pkg::ADDR_W,
  parameter int RES_W      = sharpen_pkg::RES_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              res_valid,
  input  logic [RES_W-1:0]  res_data,
  output logic              res_ready,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [PIX_W-1:0]  mem_wr_data,
  input  logic              mem_wr_ready,
  output logic              busy,
  output logic              frame_done
`ifdef SHARPEN_WB_CHECKSUM_EN
  ,
  output logic [15:0]       checksum
`endif
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int FCW   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0]  FRAME_PIX = CNT_W'(IMG_W * IMG_H);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

  wb_state_t         state;
  logic [CNT_W-1:0]  in_cnt;
  logic [ADDR_W-1:0] out_cnt;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FCW-1:0]    fifo_count;
  logic [RES_W-1:0]  fifo_head;
  logic              fifo_push;
  logic              fifo_pop;
  logic              push;
  logic              can_load;
  logic              load;
  logic              wr_accept;
  logic [RES_W-1:0]  load_res;
  logic [PIX_W-1:0]  sat_pix;

  // An empty FIFO is bypassed so a result can reach the output register the cycle after acceptance.
  always_comb begin
    res_ready = (state == RUN) && !fifo_full && (in_cnt < FRAME_PIX);
    push      = res_valid && res_ready;
    wr_accept = mem_wr_en && mem_wr_ready;
    can_load  = (state == RUN) && (!mem_wr_en || mem_wr_ready);
    load      = can_load && (!fifo_empty || push);
    fifo_pop  = can_load && !fifo_empty;
    fifo_push = push && !(fifo_empty && can_load);
    load_res  = fifo_empty ? res_data : fifo_head;
  end

  always_comb begin
    if (load_res[RES_W-1])
      sat_pix = '0;
    else if (|load_res[RES_W-2:PIX_W])
      sat_pix = '1;
    else
      sat_pix = load_res[PIX_W-1:0];
  end

  sharpen_wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (RES_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (res_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      in_cnt      <= '0;
      out_cnt     <= '0;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
`ifdef SHARPEN_WB_CHECKSUM_EN
      checksum    <= '0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            busy    <= 1'b1;
            in_cnt  <= '0;
            out_cnt <= '0;
`ifdef SHARPEN_WB_CHECKSUM_EN
            checksum <= '0;
`endif
          end
        end
        RUN: begin
          if (push) in_cnt <= in_cnt + 1'b1;
          if (load) begin
            mem_wr_en   <= 1'b1;
            mem_wr_addr <= out_cnt;
            mem_wr_data <= sat_pix;
            out_cnt     <= out_cnt + 1'b1;
          end else if (wr_accept) begin
            mem_wr_en <= 1'b0;
          end
`ifdef SHARPEN_WB_CHECKSUM_EN
          if (wr_accept) checksum <= checksum + {8'd0, mem_wr_data};
`endif
          if (wr_accept && (mem_wr_addr == LAST_ADDR) && (fifo_count == '0)) begin
            state      <= DONE;
            frame_done <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sharpen_writeback_stage.sv
// Self-checking bench for sharpen_writeback_stage on a 4x2 frame against a queue-based pixel model.
module tb_sharpen_writeback_stage;

  localparam int PIX = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        res_valid;
  logic [11:0] res_data;
  logic        res_ready;
  logic        mem_wr_en;
  logic [18:0] mem_wr_addr;
  logic [7:0]  mem_wr_data;
  logic        mem_wr_ready;
  logic        busy;
  logic        frame_done;
`ifdef SHARPEN_WB_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  int vectors = 0;
  int miscompares = 0;

  int  exp_q[$];
  int  exp_addr = 0;
  int  exp_in = 0;
  int  exp_sum = 0;
  bit  exp_busy = 0;
  bit  exp_done = 0;
  bit  prev_reset = 0;
  bit  obs_push = 0;
  bit  obs_ready = 0;
  bit  obs_done = 0;

  int ramp_vals[8] = '{0, 1, 2, 3, 4, 5, 6, 7};
  int sat_vals[8]  = '{-1, -1020, 0, 255, 256, 1275, 128, -2048};

  sharpen_writeback_stage #(
    .IMG_W      (4),
    .IMG_H      (2),
    .ADDR_W     (19),
    .RES_W      (12),
    .FIFO_DEPTH (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .res_valid    (res_valid),
    .res_data     (res_data),
    .res_ready    (res_ready),
    .mem_wr_en    (mem_wr_en),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_wr_ready (mem_wr_ready),
    .busy         (busy),
    .frame_done   (frame_done)
`ifdef SHARPEN_WB_CHECKSUM_EN
    ,
    .checksum     (checksum)
`endif
  );

  always #5 clk = ~clk;

  function automatic int satModel(input int v);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Sampled at the falling edge: checks outputs, then advances the model across the coming rising edge.
  task automatic checkOutput();
    bit next_done;
    next_done = 0;
    compare("busy", 32'(busy), 32'(exp_busy));
    compare("frame_done", 32'(frame_done), 32'(exp_done));
    if (prev_reset) begin
      compare("reset_wr_en", 32'(mem_wr_en), 0);
      compare("reset_wr_addr", 32'(mem_wr_addr), 0);
      compare("reset_wr_data", 32'(mem_wr_data), 0);
      compare("reset_res_ready", 32'(res_ready), 0);
    end
    if (!exp_busy || exp_done || exp_in >= PIX)
      compare("res_ready_blocked", 32'(res_ready), 0);
    if (mem_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        compare("spurious_write", 32'(mem_wr_en), 0);
      end else begin
        compare("wr_addr", 32'(mem_wr_addr), exp_addr);
        compare("wr_data", 32'(mem_wr_data), exp_q[0]);
      end
    end
`ifdef SHARPEN_WB_CHECKSUM_EN
    if (!exp_busy || exp_done)
      compare("checksum", 32'(checksum), exp_sum % 65536);
`endif
    obs_ready = (res_ready === 1'b1);
    obs_push  = res_valid && obs_ready;
    if (frame_done === 1'b1) obs_done = 1;
    if (reset) begin
      exp_q.delete();
      exp_addr = 0;
      exp_in   = 0;
      exp_sum  = 0;
      exp_busy = 0;
      exp_done = 0;
      obs_push = 0;
    end else begin
      if (mem_wr_en === 1'b1 && mem_wr_ready && exp_q.size() > 0) begin
        exp_sum += exp_q[0];
        void'(exp_q.pop_front());
        exp_addr++;
        if (exp_addr == PIX) next_done = 1;
      end
      if (obs_push) begin
        exp_q.push_back(satModel(int'($signed(res_data))));
        exp_in++;
      end
      if (start && !exp_busy) begin
        exp_busy = 1;
        exp_addr = 0;
        exp_in   = 0;
        exp_sum  = 0;
        exp_q.delete();
      end else if (exp_done) begin
        exp_busy = 0;
      end
      exp_done = next_done;
    end
    prev_reset = reset;
  endtask

  task automatic applyStimulus(input bit st, input bit v, input int d, input bit r, input bit rs);
    start        = st;
    res_valid    = v;
    res_data     = d[11:0];
    mem_wr_ready = r;
    reset        = rs;
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  // One frame: optional stall of mem_wr_ready, random handshakes, a stray start, or an abort by reset.
  task automatic runFrame(input int vals[8], input int stall_at, input bit rnd,
                          input int abort_after, input bit extra_start);
    int  idx = 0;
    int  cyc = 0;
    int  stall_left = 0;
    int  stall_acc = 0;
    int  phase = 0;
    int  rec_cycles = 0;
    bit  rec_ok = 0;
    bit  aborted = 0;
    bit  v, r, st, rs;
    int  d;
    obs_done = 0;
    applyStimulus(1, 0, 0, 1, 0);
    while (cyc < 300 && exp_busy) begin
      v  = (idx < PIX) ? (rnd ? ($urandom_range(0, 3) != 0) : 1'b1) : 1'b1;
      d  = (idx < PIX) ? vals[idx] : 100;
      r  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      st = extra_start && (cyc == 4);
      rs = (abort_after > 0) && (exp_addr == abort_after);
      if (stall_at >= 0 && phase == 0 && idx == stall_at) begin
        phase = 1;
        stall_left = 5;
      end
      if (phase == 1) r = 1'b0;
      applyStimulus(st, v, d, r, rs);
      if (phase == 1) begin
        if (obs_push) stall_acc++;
        stall_left--;
        if (stall_left == 0) phase = 2;
      end else if (phase == 2) begin
        rec_cycles++;
        if (obs_ready) begin
          rec_ok = (rec_cycles <= 3);
          phase = 3;
        end else if (rec_cycles > 3) begin
          phase = 3;
        end
      end
      if (obs_push) idx++;
      cyc++;
      if (rs) begin
        aborted = 1;
        break;
      end
    end
    compare("frame_timeout", 32'(cyc >= 300), 0);
    if (!aborted) compare("frame_done_seen", 32'(obs_done), 1);
    if (stall_at >= 0) begin
      compare("stall_accepts", stall_acc, 2);
      compare("ready_recovered", 32'(rec_ok), 1);
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 1, 0);
  endtask

  initial begin
    int rvals[8];
    applyStimulus(0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 1, 1);
    idleCycles(2);
    $display("[TB] ramp frame with stray start");
    runFrame(ramp_vals, -1, 0, 0, 1);
    idleCycles(2);
    $display("[TB] saturation frame");
    runFrame(sat_vals, -1, 0, 0, 0);
    idleCycles(2);
    $display("[TB] back-pressure frame");
    runFrame(ramp_vals, 3, 0, 0, 0);
    idleCycles(2);
    $display("[TB] reset abort after 3 writes");
    runFrame(ramp_vals, -1, 0, 3, 0);
    idleCycles(4);
    runFrame(ramp_vals, -1, 0, 0, 0);
    idleCycles(2);
    $display("[TB] randomized frames");
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < PIX; i++) begin
        case ($urandom_range(0, 3))
          0:       rvals[i] = $urandom_range(0, 255);
          1:       rvals[i] = $urandom_range(0, 4095) - 2048;
          2:       rvals[i] = $urandom_range(250, 262);
          default: rvals[i] = $urandom_range(0, 8) - 4;
        endcase
      end
      runFrame(rvals, -1, 1, 0, 0);
      idleCycles($urandom_range(1, 3));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
